// File: rtl/axil_ram_pipe.sv
// AXI4-Lite RAM slave with independent AW/W holding registers and an optional read output stage.
// Define AXIL_RAM_PROT_EN to reject accesses whose prot[0] (privileged) bit is clear.
module axil_ram_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 16,
    parameter int DEPTH           = 2**(ADDR_WIDTH-$clog2(DATA_WIDTH/8)),
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_PIPE, S_RESP} rd_state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  aw_held_q, w_held_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    rd_state_t             rd_state_q;
    logic                  arready_q, rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q, pipe_data_q;
    logic [1:0]            rresp_q, pipe_resp_q;

    logic [IDX_W-1:0]      rd_idx;
    logic                  wr_err, rd_err, commit, aw_acc, w_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    assign aw_acc = s_axil_awvalid && !aw_held_q;
    assign w_acc  = s_axil_wvalid && !w_held_q;
    assign commit = aw_held_q && w_held_q && (!bvalid_q || s_axil_bready);
    assign rd_idx = s_axil_araddr[ADDR_WIDTH-1:LSB];

`ifdef AXIL_RAM_PROT_EN
    logic aw_prot0_q;
    logic unused_in;
    always_ff @(posedge clk) begin
        if (aw_acc) aw_prot0_q <= s_axil_awprot[0];
    end
    assign wr_err    = ({1'b0, aw_idx_q} >= DEPTH_L) || !aw_prot0_q;
    assign rd_err    = ({1'b0, rd_idx} >= DEPTH_L) || !s_axil_arprot[0];
    assign unused_in = ^{s_axil_awaddr[LSB-1:0], s_axil_araddr[LSB-1:0],
                         s_axil_awprot[2:1], s_axil_arprot[2:1]};
`else
    logic unused_in;
    assign wr_err    = ({1'b0, aw_idx_q} >= DEPTH_L);
    assign rd_err    = ({1'b0, rd_idx} >= DEPTH_L);
    assign unused_in = ^{s_axil_awaddr[LSB-1:0], s_axil_araddr[LSB-1:0],
                         s_axil_awprot, s_axil_arprot};
`endif

    // Out-of-range reads are forced to zero so the array is never indexed past its end.
    assign rd_word = rd_err ? '0 : mem_q[rd_idx[MEM_AW-1:0]];

    // Write control: held flags and response channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
            if (aw_acc) aw_held_q <= 1'b1;
            if (w_acc) w_held_q <= 1'b1;
            if (bvalid_q && s_axil_bready) bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_acc) aw_idx_q <= s_axil_awaddr[ADDR_WIDTH-1:LSB];
        if (w_acc) begin
            w_data_q <= s_axil_wdata;
            w_strb_q <= s_axil_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (commit && !wr_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) mem_q[aw_idx_q[MEM_AW-1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
            end
        end
    end

    // Read FSM; memory is sampled before any same-edge commit lands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q  <= S_IDLE;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            pipe_data_q <= '0;
            pipe_resp_q <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                S_IDLE: begin
                    if (s_axil_arvalid) begin
                        arready_q <= 1'b0;
                        if (PIPELINE_OUTPUT != 0) begin
                            pipe_data_q <= rd_word;
                            pipe_resp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
                            rd_state_q  <= S_PIPE;
                        end else begin
                            rdata_q    <= rd_word;
                            rresp_q    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                            rvalid_q   <= 1'b1;
                            rd_state_q <= S_RESP;
                        end
                    end
                end
                S_PIPE: begin
                    rdata_q    <= pipe_data_q;
                    rresp_q    <= pipe_resp_q;
                    rvalid_q   <= 1'b1;
                    rd_state_q <= S_RESP;
                end
                S_RESP: begin
                    if (s_axil_rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= S_IDLE;
                    end
                end
                default: begin
                    rvalid_q   <= 1'b0;
                    arready_q  <= 1'b1;
                    rd_state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axil_awready = ~aw_held_q;
    assign s_axil_wready  = ~w_held_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

endmodule
